// File: rtl/resadd_rdma_v2.sv
// rtl/resadd_rdma_v2.sv - residual-add read-command generator.
// Walks CH x H x ceil(W/BL) bursts and issues one MCIF read per burst (A, optionally B).
module resadd_rdma_v2 #(
   parameter int LOG2_BURST = 4,
   parameter int PIX_BYTES  = 64,
   parameter int W_BITS     = 12,
   parameter int H_BITS     = 12,
   parameter int CH_BITS    = 10,
   parameter int ADDR_W     = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  dual_src,
   input  logic [W_BITS-1:0]     W,
   input  logic [H_BITS-1:0]     H,
   input  logic [CH_BITS-1:0]    CH_div_Tout,
   input  logic [ADDR_W-1:0]     base_addr_a,
   input  logic [ADDR_W-1:0]     base_addr_b,
   input  logic [ADDR_W-1:0]     surface_stride,
   input  logic [15:0]           line_stride,
   output logic                  busy,
   output logic                  done,
   output logic                  rd_req_vld,
   input  logic                  rd_req_rdy,
   output logic [LOG2_BURST-1:0] rd_req_len,
   output logic [ADDR_W-1:0]     rd_req_addr,
   output logic                  rd_req_src
);

   localparam int BL = 1 << LOG2_BURST;
   localparam logic [ADDR_W-1:0]     BURST_BYTES = ADDR_W'(BL * PIX_BYTES);
   localparam logic [LOG2_BURST-1:0] LEN_FULL    = LOG2_BURST'(BL - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, FIN} state_t;

   state_t                state_q, state_d;
   logic                  busy_q, busy_d, done_q, done_d, vld_q, vld_d, src_q, src_d;
   logic [LOG2_BURST-1:0] len_q, len_d, len_last_q, len_last_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic                  dual_q, dual_d;
   logic [W_BITS-1:0]     wb_last_q, wb_last_d, wb_q, wb_d;
   logic [H_BITS-1:0]     h_last_q, h_last_d, h_q, h_d;
   logic [CH_BITS-1:0]    ch_last_q, ch_last_d, ch_q, ch_d;
   logic [ADDR_W-1:0]     base_a_q, base_a_d, base_b_q, base_b_d;
   logic [ADDR_W-1:0]     surf_q, surf_d, line_q, line_d;
   logic [ADDR_W-1:0]     wb_off_q, wb_off_d, h_off_q, h_off_d, ch_off_q, ch_off_d;

   logic [W_BITS-1:0]     w_m1;
   logic                  handshake, last_cmd;

   always_comb begin
      state_d = state_q;   busy_d = busy_q;     done_d = 1'b0;
      vld_d = vld_q;       src_d = src_q;       len_d = len_q;
      addr_d = addr_q;     dual_d = dual_q;     len_last_d = len_last_q;
      wb_last_d = wb_last_q; h_last_d = h_last_q; ch_last_d = ch_last_q;
      base_a_d = base_a_q; base_b_d = base_b_q; surf_d = surf_q; line_d = line_q;
      wb_d = wb_q;         h_d = h_q;           ch_d = ch_q;
      wb_off_d = wb_off_q; h_off_d = h_off_q;   ch_off_d = ch_off_q;

      w_m1      = W - W_BITS'(1);
      handshake = vld_q && rd_req_rdy;
      last_cmd  = (!dual_q || src_q) && (wb_q == wb_last_q) &&
                  (h_q == h_last_q) && (ch_q == ch_last_q);

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               dual_d     = dual_src;
               wb_last_d  = w_m1 >> LOG2_BURST;
               len_last_d = w_m1[LOG2_BURST-1:0];
               h_last_d   = H - H_BITS'(1);
               ch_last_d  = CH_div_Tout - CH_BITS'(1);
               base_a_d   = base_addr_a;
               base_b_d   = base_addr_b;
               surf_d     = surface_stride;
               line_d     = {{(ADDR_W-16){1'b0}}, line_stride};
               wb_d = '0;     h_d = '0;     ch_d = '0;
               wb_off_d = '0; h_off_d = '0; ch_off_d = '0;
               src_d  = 1'b0;
               busy_d = 1'b1;
               if (W == '0 || H == '0 || CH_div_Tout == '0) begin
                  state_d = FIN;
                  done_d  = 1'b1;
               end else begin
                  state_d = ISSUE;
                  vld_d   = 1'b1;
                  addr_d  = base_addr_a;
                  len_d   = ((w_m1 >> LOG2_BURST) == '0) ? w_m1[LOG2_BURST-1:0] : LEN_FULL;
               end
            end
         end
         ISSUE: begin
            if (handshake) begin
               if (abort) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  vld_d   = 1'b0;
               end else if (dual_q && !src_q) begin
                  src_d  = 1'b1;
                  addr_d = base_b_q + ch_off_q + h_off_q + wb_off_q;
               end else if (last_cmd) begin
                  state_d = FIN;
                  vld_d   = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  src_d = 1'b0;
                  // Offsets are accumulated per loop level and cleared on wrap.
                  if (wb_q == wb_last_q) begin
                     wb_d = '0;
                     wb_off_d = '0;
                     if (h_q == h_last_q) begin
                        h_d = '0;
                        h_off_d = '0;
                        ch_d = ch_q + CH_BITS'(1);
                        ch_off_d = ch_off_q + surf_q;
                     end else begin
                        h_d = h_q + H_BITS'(1);
                        h_off_d = h_off_q + line_q;
                     end
                  end else begin
                     wb_d = wb_q + W_BITS'(1);
                     wb_off_d = wb_off_q + BURST_BYTES;
                  end
                  addr_d = base_a_q + ch_off_d + h_off_d + wb_off_d;
                  len_d  = (wb_d == wb_last_q) ? len_last_q : LEN_FULL;
               end
            end
         end
         FIN: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            vld_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;  busy_q <= 1'b0;  done_q <= 1'b0;  vld_q <= 1'b0;
         src_q <= 1'b0;    len_q <= '0;     addr_q <= '0;    dual_q <= 1'b0;
         len_last_q <= '0; wb_last_q <= '0; h_last_q <= '0;  ch_last_q <= '0;
         base_a_q <= '0;   base_b_q <= '0;  surf_q <= '0;    line_q <= '0;
         wb_q <= '0;       h_q <= '0;       ch_q <= '0;
         wb_off_q <= '0;   h_off_q <= '0;   ch_off_q <= '0;
      end else begin
         state_q <= state_d;  busy_q <= busy_d;  done_q <= done_d;  vld_q <= vld_d;
         src_q <= src_d;      len_q <= len_d;    addr_q <= addr_d;  dual_q <= dual_d;
         len_last_q <= len_last_d; wb_last_q <= wb_last_d;
         h_last_q <= h_last_d;     ch_last_q <= ch_last_d;
         base_a_q <= base_a_d; base_b_q <= base_b_d; surf_q <= surf_d; line_q <= line_d;
         wb_q <= wb_d;         h_q <= h_d;           ch_q <= ch_d;
         wb_off_q <= wb_off_d; h_off_q <= h_off_d;   ch_off_q <= ch_off_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign rd_req_vld  = vld_q;
   assign rd_req_len  = len_q;
   assign rd_req_addr = addr_q;
   assign rd_req_src  = src_q;

endmodule

// File: tb/tb_resadd_rdma_v2.sv
// tb/tb_resadd_rdma_v2.sv - directed table-driven bench for resadd_rdma_v2.
// Commands are checked against hand-computed address/len/src tables.
module tb_resadd_rdma_v2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, abort = 1'b0, dual_src = 1'b0;
   logic [11:0] W = '0, H = '0;
   logic [9:0]  CH_div_Tout = '0;
   logic [31:0] base_addr_a = '0, base_addr_b = '0, surface_stride = '0;
   logic [15:0] line_stride = '0;
   logic        busy, done, rd_req_vld, rd_req_src;
   logic        rd_req_rdy = 1'b0;
   logic [3:0]  rd_req_len;
   logic [31:0] rd_req_addr;

   int n_total = 0;
   int n_pass  = 0;

   resadd_rdma_v2 dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .dual_src(dual_src),
      .W(W), .H(H), .CH_div_Tout(CH_div_Tout),
      .base_addr_a(base_addr_a), .base_addr_b(base_addr_b),
      .surface_stride(surface_stride), .line_stride(line_stride),
      .busy(busy), .done(done), .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy),
      .rd_req_len(rd_req_len), .rd_req_addr(rd_req_addr), .rd_req_src(rd_req_src)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        dual;
      logic [11:0] w;
      logic [11:0] h;
      logic [9:0]  ch;
      logic [31:0] ba;
      logic [31:0] bb;
      logic [31:0] surf;
      logic [15:0] line;
      bit          rnd;
      int          first;
      int          n;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  len;
      logic        src;
   } cmd_t;

   vec_t vecs[5];
   cmd_t cmds[20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic set_cfg(input int vi);
      dual_src = vecs[vi].dual;  W = vecs[vi].w;  H = vecs[vi].h;
      CH_div_Tout = vecs[vi].ch; base_addr_a = vecs[vi].ba; base_addr_b = vecs[vi].bb;
      surface_stride = vecs[vi].surf; line_stride = vecs[vi].line;
   endtask

   task automatic do_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   // Runs one complete walk and checks every presented command, stall stability and done.
   task automatic run_walk(input int vi);
      int          idx = 0, cyc = 0, e;
      bit          stalled = 0;
      logic [31:0] pa;
      logic [3:0]  pl;
      logic        ps;
      rd_req_rdy = 1'b0;
      set_cfg(vi);
      do_start();
      W = 12'd3; H = 12'd7; base_addr_a = 32'hdead0000; base_addr_b = 32'hbeef0000;
      dual_src = ~vecs[vi].dual; line_stride = 16'h0040;
      while (idx < vecs[vi].n && cyc < 500) begin
         @(negedge clk);
         cyc++;
         chk($sformatf("v%0d_vld_c%0d", vi, cyc), {31'd0, rd_req_vld}, 32'd1);
         chk($sformatf("v%0d_nodone_c%0d", vi, cyc), {31'd0, done}, 32'd0);
         if (stalled) begin
            chk($sformatf("v%0d_hold_addr%0d", vi, idx), rd_req_addr, pa);
            chk($sformatf("v%0d_hold_len%0d", vi, idx), {28'd0, rd_req_len}, {28'd0, pl});
            chk($sformatf("v%0d_hold_src%0d", vi, idx), {31'd0, rd_req_src}, {31'd0, ps});
         end else begin
            e = vecs[vi].first + idx;
            chk($sformatf("v%0d_addr%0d", vi, idx), rd_req_addr, cmds[e].addr);
            chk($sformatf("v%0d_len%0d", vi, idx), {28'd0, rd_req_len}, {28'd0, cmds[e].len});
            chk($sformatf("v%0d_src%0d", vi, idx), {31'd0, rd_req_src}, {31'd0, cmds[e].src});
         end
         rd_req_rdy = vecs[vi].rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (rd_req_rdy) begin
            idx++;
            stalled = 0;
         end else begin
            stalled = 1;
            pa = rd_req_addr; pl = rd_req_len; ps = rd_req_src;
         end
      end
      if (cyc >= 500) begin
         n_total++;
         $display("FAIL v%0d_timeout: got %0d cmds expected %0d", vi, idx, vecs[vi].n);
      end
      @(negedge clk);
      rd_req_rdy = 1'b0;
      chk($sformatf("v%0d_end_vld", vi), {31'd0, rd_req_vld}, 32'd0);
      chk($sformatf("v%0d_done", vi), {31'd0, done}, 32'd1);
      chk($sformatf("v%0d_fin_busy", vi), {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", vi), {31'd0, done}, 32'd0);
      chk($sformatf("v%0d_idle_busy", vi), {31'd0, busy}, 32'd0);
   endtask

   initial begin
      vecs[0] = '{1'b0, 12'd40, 12'd2, 10'd1, 32'h1000, 32'h0, 32'h0, 16'h1000, 1'b0, 0, 6};
      vecs[1] = '{1'b1, 12'd16, 12'd1, 10'd2, 32'h0, 32'h80000, 32'h10000, 16'h0, 1'b0, 6, 4};
      vecs[2] = '{1'b0, 12'd40, 12'd2, 10'd1, 32'h1000, 32'h0, 32'h0, 16'h1000, 1'b1, 0, 6};
      vecs[3] = '{1'b0, 12'd17, 12'd1, 10'd1, 32'h1000, 32'h0, 32'h0, 16'h1000, 1'b0, 10, 2};
      vecs[4] = '{1'b1, 12'd20, 12'd2, 10'd1, 32'h0, 32'h4000, 32'h0, 16'h0100, 1'b1, 12, 8};
      cmds[0]  = '{32'h1000, 4'd15, 1'b0};  cmds[1]  = '{32'h1400, 4'd15, 1'b0};
      cmds[2]  = '{32'h1800, 4'd7,  1'b0};  cmds[3]  = '{32'h2000, 4'd15, 1'b0};
      cmds[4]  = '{32'h2400, 4'd15, 1'b0};  cmds[5]  = '{32'h2800, 4'd7,  1'b0};
      cmds[6]  = '{32'h0,     4'd15, 1'b0}; cmds[7]  = '{32'h80000, 4'd15, 1'b1};
      cmds[8]  = '{32'h10000, 4'd15, 1'b0}; cmds[9]  = '{32'h90000, 4'd15, 1'b1};
      cmds[10] = '{32'h1000, 4'd15, 1'b0};  cmds[11] = '{32'h1400, 4'd0,  1'b0};
      cmds[12] = '{32'h0000, 4'd15, 1'b0};  cmds[13] = '{32'h4000, 4'd15, 1'b1};
      cmds[14] = '{32'h0400, 4'd3,  1'b0};  cmds[15] = '{32'h4400, 4'd3,  1'b1};
      cmds[16] = '{32'h0100, 4'd15, 1'b0};  cmds[17] = '{32'h4100, 4'd15, 1'b1};
      cmds[18] = '{32'h0500, 4'd3,  1'b0};  cmds[19] = '{32'h4500, 4'd3,  1'b1};

      @(negedge clk);
      chk("rst_vld", {31'd0, rd_req_vld}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_addr", rd_req_addr, 32'd0);
      chk("rst_len", {28'd0, rd_req_len}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) run_walk(i);

      // Zero-size surface: straight to FIN, no commands.
      set_cfg(0);
      H = 12'd0;
      do_start();
      @(negedge clk);
      chk("zero_vld", {31'd0, rd_req_vld}, 32'd0);
      chk("zero_done", {31'd0, done}, 32'd1);
      chk("zero_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("zero_done_end", {31'd0, done}, 32'd0);
      chk("zero_busy_end", {31'd0, busy}, 32'd0);
      chk("zero_vld_end", {31'd0, rd_req_vld}, 32'd0);

      // Abort while a command is pending: it is accepted once, then the walk stops.
      set_cfg(0);
      rd_req_rdy = 1'b0;
      do_start();
      @(negedge clk);
      abort = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("abort_hold_vld%0d", k), {31'd0, rd_req_vld}, 32'd1);
         chk($sformatf("abort_hold_addr%0d", k), rd_req_addr, 32'h1000);
      end
      rd_req_rdy = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      rd_req_rdy = 1'b0;
      chk("abort_vld", {31'd0, rd_req_vld}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_nodone", {31'd0, done}, 32'd0);
      repeat (3) @(negedge clk);
      chk("abort_nodone_late", {31'd0, done}, 32'd0);
      chk("abort_vld_late", {31'd0, rd_req_vld}, 32'd0);

      // abort and start together: start is dropped.
      @(posedge clk); #1 start = 1'b1; abort = 1'b1;
      @(posedge clk); #1 start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("abort_start_vld", {31'd0, rd_req_vld}, 32'd0);
      chk("abort_start_busy", {31'd0, busy}, 32'd0);

      run_walk(0);

      // Start while busy is ignored.
      set_cfg(3);
      rd_req_rdy = 1'b0;
      do_start();
      @(posedge clk); #1 set_cfg(1); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("busy_start_addr", rd_req_addr, 32'h1000);
      chk("busy_start_src", {31'd0, rd_req_src}, 32'd0);
      rd_req_rdy = 1'b1;
      @(negedge clk);
      chk("busy_start_addr2", rd_req_addr, 32'h1400);
      chk("busy_start_len2", {28'd0, rd_req_len}, 32'd0);
      @(negedge clk);
      rd_req_rdy = 1'b0;
      chk("busy_start_done", {31'd0, done}, 32'd1);
      @(negedge clk);

      // Asynchronous reset mid-walk.
      set_cfg(0);
      rd_req_rdy = 1'b1;
      do_start();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_vld", {31'd0, rd_req_vld}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      rd_req_rdy = 1'b0;
      run_walk(0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
